// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush-driven bubble
// insertion and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic             id_branch,
  input  logic             id_MemRead,
  input  logic             id_MemtoReg,
  input  logic             id_MemWrite,
  input  logic             id_ALUSrc1,
  input  logic             id_ALUSrc2,
  input  logic             id_RegWrite,
  input  logic             id_jump,
  input  logic [2:0]       id_ALUOp,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_MemRead,
  output logic             ex_MemtoReg,
  output logic             ex_MemWrite,
  output logic             ex_ALUSrc1,
  output logic             ex_ALUSrc2,
  output logic             ex_RegWrite,
  output logic             ex_jump,
  output logic [2:0]       ex_ALUOp,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic       uses_rs1;
  logic       uses_rs2;
  logic       hazard;
  logic       bubble;
  logic [7:0] id_ctrl;
  logic [7:0] ex_ctrl;

  assign uses_rs1 = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) || (id_opcode == OP_JAL));
  assign uses_rs2 = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);

  assign hazard = id_valid && ex_valid && ex_MemRead && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));
  assign stall  = hazard && !flush;

  // Flush, stall and an empty ID slot all collapse the control bundle to zero.
  assign bubble  = flush || stall || !id_valid;
  assign id_ctrl = {id_branch, id_MemRead, id_MemtoReg, id_MemWrite,
                    id_ALUSrc1, id_ALUSrc2, id_RegWrite, id_jump};

  assign {ex_branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
          ex_ALUSrc1, ex_ALUSrc2, ex_RegWrite, ex_jump} = ex_ctrl;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_ALUOp    <= 3'b000;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      ex_valid    <= !bubble;
      ex_ctrl     <= bubble ? 8'd0 : id_ctrl;
      ex_ALUOp    <= bubble ? 3'b000 : id_ALUOp;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7b5 <= id_funct7b5;
      if (flush && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage, plus hand-written sequences for
// counter saturation and reset during a stall.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic             id_branch, id_MemRead, id_MemtoReg, id_MemWrite;
  logic             id_ALUSrc1, id_ALUSrc2, id_RegWrite, id_jump;
  logic [2:0]       id_ALUOp;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [2:0]       id_funct3;
  logic             id_funct7b5;
  logic             flush;
  logic             stall;
  logic             ex_valid;
  logic             ex_branch, ex_MemRead, ex_MemtoReg, ex_MemWrite;
  logic             ex_ALUSrc1, ex_ALUSrc2, ex_RegWrite, ex_jump;
  logic [2:0]       ex_ALUOp;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [2:0]       ex_funct3;
  logic             ex_funct7b5;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_branch(id_branch), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
    .id_MemWrite(id_MemWrite), .id_ALUSrc1(id_ALUSrc1), .id_ALUSrc2(id_ALUSrc2),
    .id_RegWrite(id_RegWrite), .id_jump(id_jump), .id_ALUOp(id_ALUOp),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite),
    .ex_ALUSrc1(ex_ALUSrc1), .ex_ALUSrc2(ex_ALUSrc2), .ex_RegWrite(ex_RegWrite),
    .ex_jump(ex_jump), .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [6:0] op;
    logic [7:0] ctrl;     // {branch,MemRead,MemtoReg,MemWrite,ALUSrc1,ALUSrc2,RegWrite,jump}
    logic [2:0] aluop;
    logic [4:0] rs1, rs2, rd;
    logic       fl;
    logic       e_stall;
    logic       e_v;
    logic [7:0] e_ctrl;
    logic [2:0] e_aluop;
    logic [3:0] e_sc, e_fc;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic v, logic [6:0] op, logic [7:0] ctrl, logic [2:0] aluop,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic fl,
                              logic e_stall, logic e_v, logic [7:0] e_ctrl, logic [2:0] e_aluop,
                              logic [3:0] e_sc, logic [3:0] e_fc);
    vec_t t;
    t.v = v; t.op = op; t.ctrl = ctrl; t.aluop = aluop;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.fl = fl;
    t.e_stall = e_stall; t.e_v = e_v; t.e_ctrl = e_ctrl; t.e_aluop = e_aluop;
    t.e_sc = e_sc; t.e_fc = e_fc;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [6:0] op, input logic [7:0] ctrl,
                       input logic [2:0] aluop, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic fl);
    id_valid  = v;
    id_opcode = op;
    {id_branch, id_MemRead, id_MemtoReg, id_MemWrite,
     id_ALUSrc1, id_ALUSrc2, id_RegWrite, id_jump} = ctrl;
    id_ALUOp    = aluop;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    flush       = fl;
    id_pc       = 32'h0000_0100 + 32'(i * 4);
    id_rs1_data = 32'hA000_0000 | 32'(i);
    id_rs2_data = 32'hB000_0000 | 32'(i);
    id_imm      = 32'hFFFF_F000 | 32'(i);
    id_funct3   = 3'(i);
    id_funct7b5 = 1'(i);
  endtask

  function automatic logic [7:0] ex_ctrl_now();
    return {ex_branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
            ex_ALUSrc1, ex_ALUSrc2, ex_RegWrite, ex_jump};
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, " ex_valid"}, 64'(ex_valid), 64'd0);
    check({tag, " ctrl"},     64'(ex_ctrl_now()), 64'd0);
    check({tag, " aluop"},    64'(ex_ALUOp), 64'd0);
    check({tag, " pc/rd"},    {27'd0, ex_rd, ex_pc}, 64'd0);
    check({tag, " data"},     {ex_rs1_data, ex_imm}, 64'd0);
    check({tag, " counters"}, 64'({stall_cnt, flush_cnt}), 64'd0);
  endtask

  initial begin
    int exp_sc;

    tbl[0]  = mk(1, R,   8'h02, 3'd2, 5'd1, 5'd2, 5'd3, 0,  0, 1, 8'h02, 3'd2, 4'd0, 4'd0);
    tbl[1]  = mk(1, LD,  8'h66, 3'd0, 5'd2, 5'd0, 5'd5, 0,  0, 1, 8'h66, 3'd0, 4'd0, 4'd0);
    tbl[2]  = mk(1, R,   8'h02, 3'd2, 5'd5, 5'd6, 5'd7, 0,  1, 0, 8'h00, 3'd0, 4'd1, 4'd0);
    tbl[3]  = mk(1, R,   8'h02, 3'd2, 5'd5, 5'd6, 5'd7, 0,  0, 1, 8'h02, 3'd2, 4'd1, 4'd0);
    tbl[4]  = mk(1, LD,  8'h66, 3'd0, 5'd1, 5'd0, 5'd0, 0,  0, 1, 8'h66, 3'd0, 4'd1, 4'd0);
    tbl[5]  = mk(1, R,   8'h02, 3'd2, 5'd0, 5'd0, 5'd4, 0,  0, 1, 8'h02, 3'd2, 4'd1, 4'd0);
    tbl[6]  = mk(1, LD,  8'h66, 3'd0, 5'd1, 5'd0, 5'd7, 0,  0, 1, 8'h66, 3'd0, 4'd1, 4'd0);
    tbl[7]  = mk(1, LUI, 8'h02, 3'd4, 5'd7, 5'd7, 5'd8, 0,  0, 1, 8'h02, 3'd4, 4'd1, 4'd0);
    tbl[8]  = mk(1, LD,  8'h66, 3'd0, 5'd1, 5'd0, 5'd7, 0,  0, 1, 8'h66, 3'd0, 4'd1, 4'd0);
    tbl[9]  = mk(1, IT,  8'h06, 3'd3, 5'd3, 5'd7, 5'd9, 0,  0, 1, 8'h06, 3'd3, 4'd1, 4'd0);
    tbl[10] = mk(1, LD,  8'h66, 3'd0, 5'd1, 5'd0, 5'd7, 0,  0, 1, 8'h66, 3'd0, 4'd1, 4'd0);
    tbl[11] = mk(1, ST,  8'h14, 3'd0, 5'd2, 5'd7, 5'd0, 0,  1, 0, 8'h00, 3'd0, 4'd2, 4'd0);
    tbl[12] = mk(1, ST,  8'h14, 3'd0, 5'd2, 5'd7, 5'd0, 0,  0, 1, 8'h14, 3'd0, 4'd2, 4'd0);
    tbl[13] = mk(1, LD,  8'h66, 3'd0, 5'd1, 5'd0, 5'd5, 0,  0, 1, 8'h66, 3'd0, 4'd2, 4'd0);
    tbl[14] = mk(1, R,   8'h02, 3'd2, 5'd5, 5'd6, 5'd7, 1,  0, 0, 8'h00, 3'd0, 4'd2, 4'd1);
    tbl[15] = mk(0, R,   8'h02, 3'd2, 5'd1, 5'd2, 5'd3, 0,  0, 0, 8'h00, 3'd0, 4'd2, 4'd1);
    tbl[16] = mk(1, BR,  8'h80, 3'd1, 5'd1, 5'd2, 5'd0, 1,  0, 0, 8'h00, 3'd0, 4'd2, 4'd2);
    tbl[17] = mk(1, JAL, 8'h03, 3'd0, 5'd0, 5'd0, 5'd1, 0,  0, 1, 8'h03, 3'd0, 4'd2, 4'd2);
    tbl[18] = mk(1, LD,  8'h66, 3'd0, 5'd1, 5'd0, 5'd5, 0,  0, 1, 8'h66, 3'd0, 4'd2, 4'd2);
    tbl[19] = mk(0, R,   8'h02, 3'd2, 5'd5, 5'd6, 5'd7, 0,  0, 0, 8'h00, 3'd0, 4'd2, 4'd2);

    rst = 1'b0;
    drive(0, 1'b0, 7'd0, 8'h00, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    check("reset stall", 64'(stall), 64'd0);

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(i, tbl[i].v, tbl[i].op, tbl[i].ctrl, tbl[i].aluop,
            tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].fl);
      #1;
      check($sformatf("v%0d stall", i), 64'(stall), 64'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      check($sformatf("v%0d ex_valid", i), 64'(ex_valid), 64'(tbl[i].e_v));
      check($sformatf("v%0d ctrl", i), 64'(ex_ctrl_now()), 64'(tbl[i].e_ctrl));
      check($sformatf("v%0d aluop", i), 64'(ex_ALUOp), 64'(tbl[i].e_aluop));
      check($sformatf("v%0d counters", i), 64'({stall_cnt, flush_cnt}),
            64'({tbl[i].e_sc, tbl[i].e_fc}));
      if (tbl[i].e_v) begin
        check($sformatf("v%0d pc", i), 64'(ex_pc), 64'(32'h0000_0100 + 32'(i * 4)));
        check($sformatf("v%0d data", i), {ex_rs1_data, ex_rs2_data},
              {32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i)});
        check($sformatf("v%0d imm", i), 64'(ex_imm), 64'(32'hFFFF_F000 | 32'(i)));
        check($sformatf("v%0d idx", i), 64'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5}),
              64'({tbl[i].rs1, tbl[i].rs2, tbl[i].rd, 3'(i), 1'(i)}));
      end
      @(negedge clk);
    end

    // Saturation: each iteration places a load in EX, then a dependent add stalls once.
    exp_sc = 2;
    for (int k = 0; k < 20; k++) begin
      drive(100, 1'b1, LD, 8'h66, 3'd0, 5'd1, 5'd0, 5'd5, 1'b0);
      @(negedge clk);
      drive(101, 1'b1, R, 8'h02, 3'd2, 5'd5, 5'd6, 5'd7, 1'b0);
      #1;
      check($sformatf("sat%0d stall", k), 64'(stall), 64'd1);
      @(posedge clk);
      #1;
      exp_sc = (exp_sc < 15) ? exp_sc + 1 : 15;
      check($sformatf("sat%0d stall_cnt", k), 64'(stall_cnt), 64'(exp_sc));
      check($sformatf("sat%0d flush_cnt", k), 64'(flush_cnt), 64'd2);
      @(negedge clk);
    end
    check("sat final", 64'(stall_cnt), 64'd15);

    // Reset arriving while a load-use stall is active.
    drive(102, 1'b1, LD, 8'h66, 3'd0, 5'd1, 5'd0, 5'd5, 1'b0);
    @(negedge clk);
    drive(103, 1'b1, R, 8'h02, 3'd2, 5'd5, 5'd6, 5'd7, 1'b0);
    #1;
    check("rststall pre stall", 64'(stall), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_cleared("rststall");
    check("rststall stall", 64'(stall), 64'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
